// File: rtl/counter_mode_ctrl.sv
// rtl/counter_mode_ctrl.sv - button debounce, run/stop FSM, mode flags and step prescaler for the up/down odd/even counter
//
// Purpose:
//   Front-end control for the 4-bit counter. Four raw push-buttons are
//   synchronised and debounced. A rising debounced edge on a button becomes
//   a one-cycle event. The events drive the STOP/RUN/PRESET state machine
//   and toggle the ud/oe mode flags. While running, a prescaler turns clk
//   into one-cycle step enables with a period of div+1 cycles.
//
// Parameters:
//   DEB_CYCLES  consecutive stable synced samples needed to accept a level change (>= 1)
//   DIV_WIDTH   width of the div input and of the prescaler counter
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         synchronous reset, active-high
//   btn_run     raw button, press toggles run/stop
//   btn_ud      raw button, press toggles up/down
//   btn_oe      raw button, press toggles odd/even
//   btn_preset  raw button, press requests a preset
//   div         step period minus 1, in clk cycles
//   mode_lock   (only with MODE_LOCK_EN) 1 = discard ud/oe events
//   en          one-cycle step enable while running
//   run         1 in RUN, or in PRESET when it returns to RUN
//   ud          1 = count up, 0 = count down
//   oe          1 = odd sequence, 0 = even sequence
//   preset      one-cycle preset request
//   mode_chg    one-cycle pulse after ud and/or oe changed
//
// Build option:
//   MODE_LOCK_EN  adds the mode_lock input

module counter_mode_ctrl #(
    parameter int DEB_CYCLES = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 btn_run,
    input  logic                 btn_ud,
    input  logic                 btn_oe,
    input  logic                 btn_preset,
    input  logic [DIV_WIDTH-1:0] div,
`ifdef MODE_LOCK_EN
    input  logic                 mode_lock,
`endif
    output logic                 en,
    output logic                 run,
    output logic                 ud,
    output logic                 oe,
    output logic                 preset,
    output logic                 mode_chg
);

    // Debounce counter only has to reach DEB_CYCLES-1; the flip happens
    // on the following mismatching sample.
    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    localparam int B_RUN = 0;
    localparam int B_UD  = 1;
    localparam int B_OE  = 2;
    localparam int B_PRE = 3;

    typedef enum logic [1:0] {
        S_STOP   = 2'd0,
        S_RUN    = 2'd1,
        S_PRESET = 2'd2
    } state_t;

    logic [3:0]       raw;
    logic [3:0]       sync1;
    logic [3:0]       sync2;
    logic [3:0]       level;
    logic [3:0]       evt;
    logic [CNT_W-1:0] deb_cnt [4];

    state_t               state;
    state_t               state_nxt;
    logic                 ret_run;
    logic                 ret_run_nxt;
    logic                 run_nxt;
    logic                 lock;
    logic                 ud_hit;
    logic                 oe_hit;
    logic                 mode_hit;
    logic                 count_go;
    logic [DIV_WIDTH-1:0] count;

    assign raw = {btn_preset, btn_oe, btn_ud, btn_run};

`ifdef MODE_LOCK_EN
    assign lock = mode_lock;
`else
    assign lock = 1'b0;
`endif

    // Two-flop synchroniser followed by a per-button debouncer. evt is a
    // registered one-cycle pulse on a rising debounced flip only.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
            level <= '0;
            evt   <= '0;
            for (int i = 0; i < 4; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 4; i++) begin
                evt[i] <= 1'b0;
                if (sync2[i] == level[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    level[i]   <= sync2[i];
                    deb_cnt[i] <= '0;
                    evt[i]     <= sync2[i];
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Next-state decode. ret_run holds the state PRESET returns to; a run
    // event coinciding with (or arriving during) PRESET toggles it.
    always_comb begin
        ud_hit      = evt[B_UD] & ~lock;
        oe_hit      = evt[B_OE] & ~lock;
        mode_hit    = ud_hit | oe_hit;
        state_nxt   = state;
        ret_run_nxt = ret_run;
        case (state)
            S_STOP: begin
                if (evt[B_PRE]) begin
                    state_nxt   = S_PRESET;
                    ret_run_nxt = evt[B_RUN];
                end else if (evt[B_RUN]) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (evt[B_PRE]) begin
                    state_nxt   = S_PRESET;
                    ret_run_nxt = ~evt[B_RUN];
                end else if (evt[B_RUN]) begin
                    state_nxt = S_STOP;
                end
            end
            S_PRESET: begin
                // A preset event here is deliberately ignored.
                state_nxt = (ret_run ^ evt[B_RUN]) ? S_RUN : S_STOP;
            end
            default: begin
                state_nxt = S_STOP;
            end
        endcase
        run_nxt  = (state_nxt == S_RUN) || ((state_nxt == S_PRESET) && ret_run_nxt);
        // Prescaler only advances while staying in RUN with no mode toggle;
        // entering RUN, leaving it and any toggle restart it from zero.
        count_go = (state == S_RUN) && (state_nxt == S_RUN) && !mode_hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_STOP;
            ret_run  <= 1'b0;
            count    <= '0;
            en       <= 1'b0;
            run      <= 1'b0;
            ud       <= 1'b1;
            oe       <= 1'b0;
            preset   <= 1'b0;
            mode_chg <= 1'b0;
        end else begin
            state    <= state_nxt;
            ret_run  <= ret_run_nxt;
            run      <= run_nxt;
            preset   <= (state_nxt == S_PRESET);
            ud       <= ud ^ ud_hit;
            oe       <= oe ^ oe_hit;
            mode_chg <= mode_hit;
            if (count_go) begin
                // >= so that lowering div below the count fires at once.
                if (count >= div) begin
                    en    <= 1'b1;
                    count <= '0;
                end else begin
                    en    <= 1'b0;
                    count <= count + 1'b1;
                end
            end else begin
                en    <= 1'b0;
                count <= '0;
            end
        end
    end

endmodule

// File: doc/counter_mode_ctrl.md
Name: counter_mode_ctrl

Overview:
Upstream control stage for the 4-bit up/down odd/even counter. It debounces four raw push-buttons and keeps the run/stop, up/down and odd/even mode flags. Its prescaler emits a single-cycle step enable while running and issues a one-cycle preset request. Its outputs drive the counter's en, ud, oe and preset inputs directly.

Parameters:
DEB_CYCLES, 4, consecutive stable synced samples needed to accept a button level change (min 1)
DIV_WIDTH, 16, width of the prescaler divide input and its counter

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
btn_run  input  1  raw button; rising debounced edge toggles run/stop
btn_ud  input  1  raw button; rising debounced edge toggles up/down
btn_oe  input  1  raw button; rising debounced edge toggles odd/even
btn_preset  input  1  raw button; rising debounced edge requests preset
div  input  DIV_WIDTH  step period minus 1, in clk cycles
en  output  1  step enable, one-cycle pulse per step while running
run  output  1  level, 1 = RUN state or PRESET returning to RUN
ud  output  1  1 = count up, 0 = count down
oe  output  1  1 = odd sequence, 0 = even sequence
preset  output  1  one-cycle preset request
mode_chg  output  1  one-cycle pulse when ud and/or oe changed

Behaviour:
- Reset (rst=1 at an edge) sets: state STOP, en=0, run=0, ud=1, oe=0, preset=0, mode_chg=0. It also clears the prescaler, both sync flops of every button, debounced levels and debounce counters.
- Reset mid-operation: all of the above takes effect on that edge. A button still held through reset is seen as a fresh press after release of rst and produces one event.
- Synchroniser: two flops per button.
- Debounce:
  - Counter increments each cycle the synced value differs from the debounced level.
  - Counter clears when they are equal.
  - On reaching DEB_CYCLES, the level flips and the counter clears.
  - A rising flip registers a one-cycle event on the same edge.
  - Glitches shorter than DEB_CYCLES samples produce no event.
- Latency: the FSM and mode flags react DEB_CYCLES+3 edges after the first edge that samples the raw button high (7 at default).
- Falling debounced edges produce no event.
- FSM states: STOP, RUN, PRESET.
  - STOP: run event goes to RUN; preset event goes to PRESET with return=STOP.
  - RUN: run event goes to STOP; preset event goes to PRESET with return=RUN.
  - PRESET: lasts exactly one cycle with preset=1 and en=0, then goes to the return state.
- Simultaneous run and preset events: PRESET is taken and the return state is the toggled run state.
- Events arriving during the PRESET cycle are processed normally on that edge; the preset event itself is ignored.
- Mode flags: ud and oe events toggle their flag on the FSM edge in any state. Both may toggle on the same edge, with a single mode_chg pulse. mode_chg is high for the cycle after the edge.
- Prescaler:
  - Held at 0 outside RUN.
  - In RUN, increments each cycle.
  - en=1 in the cycle where count >= div, and the count wraps to 0.
  - div=0 gives en every RUN cycle.
  - Lowering div below the current count forces en on the next cycle.
- Prescaler clearing: the prescaler clears on entry to RUN, on any mode toggle and on PRESET. Consequences:
  - the first en comes div+1 cycles after entering RUN;
  - en is never high in the same cycle that ud or oe changes.
- run equals 1 in RUN, and in PRESET when return=RUN.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
Macro MODE_LOCK_EN.
- Defined: adds input port mode_lock (1 bit, after div). While mode_lock=1, ud and oe events are discarded (no toggle, no mode_chg); run and preset events still act. An event is discarded if mode_lock is high on the FSM edge.
- Undefined: no mode_lock port; ud and oe events are always honoured.

Test Plan:
- Reset, then idle 20 cycles -> en=0, run=0, ud=1, oe=0, preset=0, mode_chg=0 throughout.
- btn_run held high 10 cycles, div=3 -> run=1 at edge 7 after the first sample; en pulses at the 4th cycle after entry and every 4 cycles after that; second press -> run=0 and en stops.
- btn_ud glitch of 3 cycles (DEB_CYCLES=4) -> no toggle; 4-cycle press -> ud 1 to 0, mode_chg one pulse, no en in that cycle, prescaler restarts (next en 4 cycles later with div=3).
- btn_run and btn_preset pressed on the same cycle from STOP -> preset=1 for exactly one cycle, en=0, then run=1; next en div+1 cycles after PRESET.
- In RUN, div=10, wait until the prescaler reaches 7, set div=2 -> en on the next cycle, then every 3 cycles.
- rst asserted mid-RUN while btn_oe is held -> all outputs take reset values on that edge; oe toggles to 1 DEB_CYCLES+3 edges after rst deasserts. With MODE_LOCK_EN and mode_lock=1, the same press leaves oe=0 and mode_chg=0.
